// File: rtl/pueo_cmd_pkg.sv
// Shared field positions, encodings and special codes for the TURF command word.
package pueo_cmd_pkg;

  localparam int unsigned MSG_N_BIT  = 31;
  localparam int unsigned RUNCMD_LSB = 26;
  localparam int unsigned M1TYPE_LSB = 24;
  localparam int unsigned M1DATA_LSB = 16;
  localparam int unsigned TRIG_BIT   = 15;

  typedef enum logic [1:0] {
    RUN_NOP  = 2'b00,
    RUN_SYNC = 2'b01,
    RUN_RST  = 2'b10,
    RUN_STOP = 2'b11
  } runcmd_e;

  typedef enum logic [1:0] {
    M1_SPECIAL = 2'b00,
    M1_NORMAL  = 2'b01,
    M1_LAST    = 2'b10,
    M1_FW      = 2'b11
  } m1type_e;

  localparam logic [7:0] SPECIAL_CMDPROC_RST = 8'h01;
  localparam logic [7:0] SPECIAL_PPS         = 8'h02;
  localparam logic [7:0] SPECIAL_FW_FLUSH    = 8'h03;

endpackage

// File: rtl/pueo_cmd_fifo.sv
// First-word-fall-through FIFO with flush and sticky overflow on dropped pushes.
module pueo_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             sysclk_i,
  input  logic             sysclk_rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  input  logic             flush,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = valid & pop;
  // A pop in the same cycle frees the slot the push lands in, so full is no obstacle.
  assign do_push = push & (~full | do_pop);
  assign q       = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
      if (do_push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (push && !do_push)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (do_push && !flush)
      mem[wr_ptr[AW-1:0]] <= data;
  end

endmodule

// File: rtl/pueo_command_decoder_v2.sv
// Decodes TURF command words into run-control/PPS/trigger pulses and two byte streams.
module pueo_command_decoder_v2
  import pueo_cmd_pkg::*;
#(
  parameter int unsigned TRIG_TIME_BITS   = 15,
  parameter int unsigned MODE1_FIFO_DEPTH = 16,
  parameter int unsigned FW_FIFO_DEPTH    = 16
) (
  input  logic                      sysclk_i,
  input  logic                      sysclk_rst_i,
  input  logic [31:0]               command_i,
  input  logic                      command_valid_i,
  output logic                      rundosync_o,
  output logic                      runrst_o,
  output logic                      runstop_o,
  output logic                      pps_o,
  output logic                      cmdproc_rst_o,
  output logic [7:0]                cmdproc_tdata,
  output logic                      cmdproc_tvalid,
  output logic                      cmdproc_tlast,
  input  logic                      cmdproc_tready,
  output logic [7:0]                fw_tdata,
  output logic                      fw_tvalid,
  input  logic                      fw_tready,
  output logic [TRIG_TIME_BITS-1:0] trig_time_o,
  output logic                      trig_valid_o,
  output logic                      mode1_overflow_o,
  output logic                      fw_overflow_o
);

  runcmd_e    runcmd;
  m1type_e    m1type;
  logic [7:0] m1data;
  logic       msg;
  logic       special;
  logic       trig;

  logic       m1_push_r;
  logic [8:0] m1_data_r;
  logic       fw_push_r;
  logic [7:0] fw_data_r;
  logic       fw_flush_r;
  logic [8:0] m1_q;
  logic       unused_m1_full;
  logic       unused_fw_full;
  logic       unused_cmd;

  // Every command bit is consumed somewhere or deliberately ignored.
  assign unused_cmd = ^command_i;

  always_comb begin
    msg     = command_valid_i & ~command_i[MSG_N_BIT];
    trig    = command_valid_i & command_i[TRIG_BIT];
    runcmd  = runcmd_e'(command_i[RUNCMD_LSB +: 2]);
    m1type  = m1type_e'(command_i[M1TYPE_LSB +: 2]);
    m1data  = command_i[M1DATA_LSB +: 8];
    special = msg && (m1type == M1_SPECIAL);
  end

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      trig_valid_o  <= 1'b0;
      trig_time_o   <= '0;
      rundosync_o   <= 1'b0;
      runrst_o      <= 1'b0;
      runstop_o     <= 1'b0;
      pps_o         <= 1'b0;
      cmdproc_rst_o <= 1'b0;
      fw_flush_r    <= 1'b0;
      m1_push_r     <= 1'b0;
      m1_data_r     <= '0;
      fw_push_r     <= 1'b0;
      fw_data_r     <= '0;
    end else begin
      trig_valid_o <= trig;
      if (trig)
        trig_time_o <= command_i[TRIG_TIME_BITS-1:0];
      rundosync_o   <= msg && (runcmd == RUN_SYNC);
      runrst_o      <= msg && (runcmd == RUN_RST);
      runstop_o     <= msg && (runcmd == RUN_STOP);
      pps_o         <= special && (m1data == SPECIAL_PPS);
      cmdproc_rst_o <= special && (m1data == SPECIAL_CMDPROC_RST);
      fw_flush_r    <= special && (m1data == SPECIAL_FW_FLUSH);
      m1_push_r     <= msg && ((m1type == M1_NORMAL) || (m1type == M1_LAST));
      m1_data_r     <= {m1type == M1_LAST, m1data};
      fw_push_r     <= msg && (m1type == M1_FW);
      fw_data_r     <= m1data;
    end
  end

  // The registered cmdproc reset pulse doubles as the mode1 flush request.
  pueo_cmd_fifo #(
    .WIDTH (9),
    .DEPTH (MODE1_FIFO_DEPTH)
  ) u_mode1_fifo (
    .sysclk_i     (sysclk_i),
    .sysclk_rst_i (sysclk_rst_i),
    .push         (m1_push_r),
    .data         (m1_data_r),
    .full         (unused_m1_full),
    .pop          (cmdproc_tready),
    .valid        (cmdproc_tvalid),
    .q            (m1_q),
    .flush        (cmdproc_rst_o),
    .overflow     (mode1_overflow_o)
  );

  assign cmdproc_tdata = m1_q[7:0];
  assign cmdproc_tlast = m1_q[8];

  pueo_cmd_fifo #(
    .WIDTH (8),
    .DEPTH (FW_FIFO_DEPTH)
  ) u_fw_fifo (
    .sysclk_i     (sysclk_i),
    .sysclk_rst_i (sysclk_rst_i),
    .push         (fw_push_r),
    .data         (fw_data_r),
    .full         (unused_fw_full),
    .pop          (fw_tready),
    .valid        (fw_tvalid),
    .q            (fw_tdata),
    .flush        (fw_flush_r),
    .overflow     (fw_overflow_o)
  );

endmodule
